// File: rtl/hog_pkg.sv
// Shared constants and state encoding for the HOG cell-fetch scheduler.
package hog_pkg;

   localparam int CELL_COLS = 40;
   localparam int CELL_ROWS = 30;
   localparam int TOTAL     = CELL_COLS * CELL_ROWS;
   localparam int ADDR_W    = 11;
   localparam int ROW_W     = 5;
   localparam int COL_W     = 6;
   localparam int CREDITS   = 4;
   localparam int CNT_W     = 3;
   localparam int FETCH_LAT = 3;
   // At most one ready strobe per cycle, each outstanding for FETCH_LAT cycles.
   localparam int PIPE_W    = $clog2(FETCH_LAT + 1);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      RESYNC,
      DONE
   } state_t;

endpackage

// File: rtl/hog_cell_sched_if.sv
// Window-memory, fetch-datapath and consumer handshake bundle of the scheduler.
interface hog_cell_sched_if;
   import hog_pkg::*;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic              fetch_ready;
   logic              fetch_rst_n;
   logic              fetch_valid;
   logic              cons_ack;
   logic [ROW_W-1:0]  cell_row;
   logic [COL_W-1:0]  cell_col;

   modport master (
      output mem_req, mem_addr, fetch_ready, fetch_rst_n, cell_row, cell_col,
      input  mem_gnt, mem_rvalid, fetch_valid, cons_ack
   );

   modport slave (
      input  mem_req, mem_addr, fetch_ready, fetch_rst_n, cell_row, cell_col,
      output mem_gnt, mem_rvalid, fetch_valid, cons_ack
   );

endinterface

// File: rtl/hog_cell_cnt.sv
// Raster cell counter: column fastest, linear address kept alongside so no
// row*CELL_COLS multiply is needed.
module hog_cell_cnt
   import hog_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_adv,
   output logic [ROW_W-1:0]  o_row,
   output logic [COL_W-1:0]  o_col,
   output logic [ADDR_W-1:0] o_addr
);

   logic [ROW_W-1:0]  r_row;
   logic [COL_W-1:0]  r_col;
   logic [ADDR_W-1:0] r_addr;

   // Advance one cell per accepted request; wrap column at the end of each row.
   always_ff @(posedge clk) begin
      if (!rst || i_clr) begin
         r_row  <= '0;
         r_col  <= '0;
         r_addr <= '0;
      end else if (i_adv) begin
         r_addr <= r_addr + ADDR_W'(1);
         if (r_col == COL_W'(CELL_COLS - 1)) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_addr = r_addr;

endmodule

// File: rtl/hog_cell_sched.sv
// Frame scheduler for the HOG cell-histogram fetch stage: credit-limited
// window issue, ready forwarding, return counting, abort drain and resync.
module hog_cell_sched
   import hog_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_abort,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_abort_done,
   output logic              o_err,
   hog_cell_sched_if.master  bus
);

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_credits;
   logic [CNT_W-1:0]   r_mem_out;
   logic [PIPE_W-1:0]  r_pipe_out;
   logic [ADDR_W-1:0]  r_issue_cnt;
   logic [ADDR_W-1:0]  r_ret_cnt;
   logic               r_err;

   logic w_busy, w_frame_done, w_abort_done, w_fetch_rst_n, w_run, w_fwd;
   logic w_start, w_req, w_grant, w_rv_ok, w_fv_ok, w_ack_ok, w_err_evt;

   // A start is only honoured from IDLE; it also wins over a simultaneous abort there.
   assign w_start  = (r_state == IDLE) && i_start;
   // Abort masks the request combinationally so nothing is granted in the abort cycle.
   assign w_req    = w_run && !i_abort && (r_credits != '0) &&
                     (r_issue_cnt < ADDR_W'(TOTAL));
   assign w_grant  = w_req && bus.mem_gnt;
   // Protocol events are accepted only when something is actually outstanding.
   assign w_rv_ok  = bus.mem_rvalid && w_fwd && (r_mem_out != '0);
   assign w_fv_ok  = bus.fetch_valid && (r_pipe_out != '0);
   assign w_ack_ok = bus.cons_ack && (r_credits != CNT_W'(CREDITS));
   assign w_err_evt = (bus.mem_rvalid && !w_rv_ok) ||
                      (bus.fetch_valid && !w_fv_ok) ||
                      (bus.cons_ack && !w_ack_ok);

   hog_cell_cnt u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_start),
      .i_adv  (w_grant),
      .o_row  (bus.cell_row),
      .o_col  (bus.cell_col),
      .o_addr (bus.mem_addr)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      w_state_next  = r_state;
      w_busy        = 1'b1;
      w_frame_done  = 1'b0;
      w_abort_done  = 1'b0;
      w_fetch_rst_n = 1'b1;
      w_run         = 1'b0;
      w_fwd         = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (i_start) w_state_next = RUN;
         end
         RUN: begin
            w_run = 1'b1;
            w_fwd = 1'b1;
            if (i_abort)                            w_state_next = DRAIN;
            else if (r_ret_cnt == ADDR_W'(TOTAL))   w_state_next = DONE;
         end
         DRAIN: begin
            w_fwd = 1'b1;
            if ((r_mem_out == '0) && (r_pipe_out == '0)) w_state_next = RESYNC;
         end
         RESYNC: begin
            w_abort_done  = 1'b1;
            w_fetch_rst_n = 1'b0;
            w_state_next  = IDLE;
         end
         DONE: begin
            w_frame_done = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Credits and in-flight counts; simultaneous +1/-1 cancel out naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_credits  <= CNT_W'(CREDITS);
         r_mem_out  <= '0;
         r_pipe_out <= '0;
      end else begin
         r_credits  <= r_credits - CNT_W'(w_grant) + CNT_W'(w_ack_ok);
         r_mem_out  <= r_mem_out + CNT_W'(w_grant) - CNT_W'(w_rv_ok);
         r_pipe_out <= r_pipe_out + PIPE_W'(w_rv_ok) - PIPE_W'(w_fv_ok);
      end
   end

   // Per-frame issue and return counters, cleared when a frame starts.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
      end else if (w_start) begin
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
      end else begin
         r_issue_cnt <= r_issue_cnt + ADDR_W'(w_grant);
         r_ret_cnt   <= r_ret_cnt + ADDR_W'(w_fv_ok);
      end
   end

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_err_evt) begin
         r_err <= 1'b1;
      end
   end

   assign bus.mem_req     = w_req;
   assign bus.fetch_ready = w_rv_ok;
   assign bus.fetch_rst_n = w_fetch_rst_n;
   assign o_busy          = w_busy;
   assign o_frame_done    = w_frame_done;
   assign o_abort_done    = w_abort_done;
   assign o_err           = r_err;

endmodule
